// File: rtl/sm3_msg_pad.sv
// SM3 message padder: packs 32-bit words into 512-bit blocks, appends the 0x80
// marker and 64-bit bit length, and sequences the compression core per block.
module sm3_msg_pad #(
  parameter logic [255:0] IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [31:0]  i_data,
  input  logic         i_last,
  input  logic [2:0]   i_nbytes,
  output logic         o_ready,
  output logic         o_core_start,
  output logic [511:0] o_core_data,
  output logic [255:0] o_core_vin,
  input  logic [255:0] i_core_vout,
  input  logic         i_core_done,
  output logic [255:0] o_hash,
  output logic         o_hash_valid
);

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_PAD   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] MARK_WORD = 32'h8000_0000;

  logic [2:0]         r_state;
  logic [0:15][31:0]  r_blk;        // index 0 is W0, lands in [511:480]
  logic [4:0]         r_wcnt;
  logic [63:0]        r_bytes;
  logic [255:0]       r_h;
  logic               r_final;      // current block carries the length
  logic               r_pend_len;   // one more length-only block is needed
  logic               r_need_mark;  // 0x80 word still has to be placed

  logic [2:0]  w_nb;
  logic [31:0] w_last_word;
  logic [63:0] w_bitlen;

  assign w_nb     = (i_nbytes > 3'd4) ? 3'd4 : i_nbytes;
  assign w_bitlen = r_bytes << 3;

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    w_last_word = i_data;
    case (w_nb)
      3'd0:    w_last_word = MARK_WORD;
      3'd1:    w_last_word = {i_data[31:24], 8'h80, 16'h0000};
      3'd2:    w_last_word = {i_data[31:16], 8'h80, 8'h00};
      3'd3:    w_last_word = {i_data[31:8], 8'h80};
      default: w_last_word = i_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FILL;
      // NOTE: the block buffer is flops, not RAM, so it is cleared like any
      // other register and o_core_data reads zero after reset.
      r_blk       <= '0;
      r_wcnt      <= '0;
      r_bytes     <= '0;
      r_h         <= IV;
      r_final     <= 1'b0;
      r_pend_len  <= 1'b0;
      r_need_mark <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (i_valid) begin
            r_wcnt <= r_wcnt + 5'd1;
            if (i_last) begin
              r_blk[r_wcnt[3:0]] <= w_last_word;
              r_bytes            <= r_bytes + {61'd0, w_nb};
              r_need_mark        <= (w_nb == 3'd4);
              r_state            <= S_PAD;
            end else begin
              r_blk[r_wcnt[3:0]] <= i_data;
              r_bytes            <= r_bytes + 64'd4;
              if (r_wcnt == 5'd15) begin
                r_final    <= 1'b0;
                r_pend_len <= 1'b0;
                r_state    <= S_START;
              end
            end
          end
        end

        S_PAD: begin
          // A marker still pending at word 16 is carried into the length block.
          if (r_wcnt[4]) begin
            r_pend_len <= !r_final;
            r_state    <= S_START;
          end else if (r_need_mark) begin
            r_blk[r_wcnt[3:0]] <= MARK_WORD;
            r_need_mark        <= 1'b0;
            r_wcnt             <= r_wcnt + 5'd1;
          end else if (r_wcnt == 5'd14) begin
            r_blk[14] <= w_bitlen[63:32];
            r_blk[15] <= w_bitlen[31:0];
            r_wcnt    <= 5'd16;
            r_final   <= 1'b1;
          end else begin
            r_blk[r_wcnt[3:0]] <= '0;
            r_wcnt             <= r_wcnt + 5'd1;
          end
        end

        S_START: r_state <= S_WAIT;

        S_WAIT: begin
          if (i_core_done) begin
            r_h <= i_core_vout;
            if (r_final) begin
              r_state <= S_DONE;
            end else if (r_pend_len) begin
              r_blk[0] <= r_need_mark ? MARK_WORD : 32'd0;
              for (int i = 1; i < 14; i++) r_blk[i] <= '0;
              r_blk[14]   <= w_bitlen[63:32];
              r_blk[15]   <= w_bitlen[31:0];
              r_final     <= 1'b1;
              r_pend_len  <= 1'b0;
              r_need_mark <= 1'b0;
              r_state     <= S_START;
            end else begin
              r_wcnt  <= '0;
              r_state <= S_FILL;
            end
          end
        end

        S_DONE: begin
          r_h         <= IV;
          r_bytes     <= '0;
          r_wcnt      <= '0;
          r_final     <= 1'b0;
          r_pend_len  <= 1'b0;
          r_need_mark <= 1'b0;
          r_state     <= S_FILL;
        end

        default: r_state <= S_FILL;
      endcase
    end
  end

  assign o_ready      = (r_state == S_FILL);
  assign o_core_start = (r_state == S_START) && !i_rst;
  assign o_hash_valid = (r_state == S_DONE) && !i_rst;
  assign o_hash       = o_hash_valid ? r_h : '0;
  assign o_core_data  = r_blk;
  assign o_core_vin   = r_h;

endmodule

// File: tb/tb_sm3_msg_pad.sv
// Bench for sm3_msg_pad: behavioural SM3 core plus a byte-level padding model
// that predicts every block, chaining value and digest.
module tb_sm3_msg_pad;

  localparam logic [255:0] IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [255:0] H_ABC = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] H_ABCD16 = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;
  localparam logic [255:0] H_EMPTY = 256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [31:0]  i_data;
  logic         i_last;
  logic [2:0]   i_nbytes;
  logic         o_ready;
  logic         o_core_start;
  logic [511:0] o_core_data;
  logic [255:0] o_core_vin;
  logic [255:0] core_vout;
  logic         core_done;
  logic [255:0] o_hash;
  logic         o_hash_valid;

  always #5 clk = ~clk;

  sm3_msg_pad #(.IV(IV)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .i_nbytes(i_nbytes), .o_ready(o_ready), .o_core_start(o_core_start),
    .o_core_data(o_core_data), .o_core_vin(o_core_vin), .i_core_vout(core_vout),
    .i_core_done(core_done), .o_hash(o_hash), .o_hash_valid(o_hash_valid)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  int n_hv = 0;
  int core_lat = 2;

  logic [511:0] exp_blk[$];
  logic [255:0] exp_vin[$];
  logic [255:0] exp_hash[$];
  logic [511:0] blk_log[$];
  logic [255:0] hash_log[$];

  typedef struct {
    int           len;
    int           period;
    int           starts;
    logic [31:0]  w0;
    logic [31:0]  w15;
    logic [31:0]  prev_w14;
    bit           known;
    logic [255:0] digest;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [511:0] z32(input logic [31:0] x);
    return {480'd0, x};
  endfunction

  function automatic logic [511:0] z256(input logic [255:0] x);
    return {256'd0, x};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SM3 compression function (reference core) ----------------
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 9) ^ rol(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  function automatic logic [255:0] sm3_compress(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w[68];
    logic [31:0] w1[64];
    logic [31:0] a, bb, c, d, e, f, g, h, t, ss1, ss2, tt1, tt2, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rol(rol(a, 12) + e + rol(t, j), 7);
      ss2 = ss1 ^ rol(a, 12);
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + w1[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rol(bb, 9); bb = a; a = tt1;
      h = g; g = rol(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  // ---------------- padding model: byte-level SM3 padding rules ----------------
  task automatic model_push(input logic [7:0] m[$]);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] b;
    logic [255:0] v;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    v = IV;
    for (int k = 0; k < p.size() / 64; k++) begin
      for (int i = 0; i < 64; i++) b[511 - 8*i -: 8] = p[64*k + i];
      exp_blk.push_back(b);
      exp_vin.push_back(v);
      v = sm3_compress(v, b);
    end
    exp_hash.push_back(v);
  endtask

  task automatic build_msg(input int len, input int period, output logic [7:0] m[$]);
    m = {};
    for (int i = 0; i < len; i++) m.push_back(8'h61 + 8'(i % period));
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit rand_valid);
    int nw;
    nw = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      int nb;
      int n;
      if (rand_valid) begin
        while ($urandom_range(0, 2) == 0) begin
          i_valid  = 1'b0;
          i_data   = $urandom;
          i_last   = 1'($urandom_range(0, 1));
          i_nbytes = 3'($urandom_range(0, 4));
          @(negedge clk);
        end
      end
      d = $urandom;  // unused byte lanes carry garbage that must be masked
      for (int k = 0; k < 4; k++)
        if (4*w + k < m.size()) d[31 - 8*k -: 8] = m[4*w + k];
      nb = m.size() - 4*w;
      if (nb > 4) nb = 4;
      i_valid  = 1'b1;
      i_data   = d;
      i_last   = (w == nw - 1);
      i_nbytes = (w == nw - 1) ? 3'(nb) : 3'($urandom_range(0, 7));
      n = 0;
      while (!o_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!o_ready) begin
        check("ready_timeout", z32({31'd0, o_ready}), z32(32'd1));
        i_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_hash(input int target);
    int n;
    n = 0;
    while (n_hv < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("hash_count", z32(32'(n_hv)), z32(32'(target)));
  endtask

  // ---------------- compression core model ----------------
  initial begin
    logic [511:0] cap_data;
    logic [255:0] cap_vin;
    int  cnt;
    bit  busy;
    bit  stale;
    core_done = 1'b0;
    core_vout = '0;
    busy = 1'b0;
    stale = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst && busy) stale = 1'b1;
      if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          if (!stale) begin
            check("core_data_stable", o_core_data, cap_data);
            check("core_vin_stable", z256(o_core_vin), z256(cap_vin));
          end
          core_done = 1'b1;
          core_vout = sm3_compress(cap_vin, cap_data);
          busy = 1'b0;
        end
      end else if (o_core_start && !rst) begin
        cap_data = o_core_data;
        cap_vin  = o_core_vin;
        cnt      = core_lat;
        busy     = 1'b1;
        stale    = 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_outputs_quiet", {254'd0, o_core_start, o_hash_valid, o_hash}, '0);
      end else begin
        if (o_core_start) begin
          n_starts++;
          blk_log.push_back(o_core_data);
          if (exp_blk.size() == 0) begin
            check("unexpected_start", z32(32'd1), z32(32'd0));
          end else begin
            check("core_data", o_core_data, exp_blk.pop_front());
            check("core_vin", z256(o_core_vin), z256(exp_vin.pop_front()));
          end
        end
        if (o_hash_valid) begin
          n_hv++;
          hash_log.push_back(o_hash);
          if (exp_hash.size() == 0) check("unexpected_hash", z32(32'd1), z32(32'd0));
          else check("digest_model", z256(o_hash), z256(exp_hash.pop_front()));
        end else begin
          check("hash_idle_zero", z256(o_hash), '0);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]   m[$];
    logic [511:0] lb;
    logic [511:0] pb;
    int           s0;
    int           h0;

    tbl[0] = '{3,  3, 1, 32'h61626380, 32'h00000018, 32'h0,        1'b1, H_ABC};
    tbl[1] = '{64, 4, 2, 32'h80000000, 32'h00000200, 32'h61626364, 1'b1, H_ABCD16};
    tbl[2] = '{0,  3, 1, 32'h80000000, 32'h00000000, 32'h0,        1'b1, H_EMPTY};
    tbl[3] = '{56, 4, 2, 32'h00000000, 32'h000001c0, 32'h80000000, 1'b0, '0};

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_nbytes = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", z32({31'd0, o_ready}), z32(32'd1));
    check("reset_vin_iv", z256(o_core_vin), z256(IV));
    check("reset_block_zero", o_core_data, '0);

    // Directed vectors from the table.
    for (int i = 0; i < 4; i++) begin
      build_msg(tbl[i].len, tbl[i].period, m);
      model_push(m);
      s0 = n_starts;
      h0 = n_hv;
      core_lat = 1 + i;
      send_msg(m, 1'b0);
      wait_hash(h0 + 1);
      check("starts", z32(32'(n_starts - s0)), z32(32'(tbl[i].starts)));
      lb = blk_log[blk_log.size() - 1];
      check("last_w0", z32(lb[511:480]), z32(tbl[i].w0));
      check("last_w15", z32(lb[31:0]), z32(tbl[i].w15));
      if (tbl[i].starts > 1) begin
        pb = blk_log[blk_log.size() - 2];
        check("prev_w14", z32(pb[63:32]), z32(tbl[i].prev_w14));
      end
      if (tbl[i].known) check("digest_known", z256(hash_log[hash_log.size() - 1]), z256(tbl[i].digest));
    end

    // Random messages with random valid gaps and core latency.
    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(0, 140);
      m = {};
      for (int k = 0; k < len; k++) m.push_back(8'($urandom));
      core_lat = $urandom_range(1, 5);
      model_push(m);
      h0 = n_hv;
      send_msg(m, 1'b1);
      wait_hash(h0 + 1);
    end

    // Reset while the core is busy, then a late core result must be ignored.
    core_lat = 25;
    build_msg(64, 4, m);
    model_push(m);
    send_msg(m, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_blk.delete();
    exp_vin.delete();
    exp_hash.delete();
    @(negedge clk);
    check("midwait_rst_ready", z32({31'd0, o_ready}), z32(32'd1));
    check("midwait_rst_vin", z256(o_core_vin), z256(IV));
    check("midwait_rst_block", o_core_data, '0);
    h0 = n_hv;
    repeat (30) @(negedge clk);
    check("late_done_ready", z32({31'd0, o_ready}), z32(32'd1));
    check("late_done_vin_iv", z256(o_core_vin), z256(IV));
    core_lat = 3;
    build_msg(3, 3, m);
    model_push(m);
    send_msg(m, 1'b0);
    wait_hash(h0 + 1);
    repeat (20) @(negedge clk);
    check("single_hash_pulse", z32(32'(n_hv - h0)), z32(32'd1));
    check("abc_after_rst", z256(hash_log[hash_log.size() - 1]), z256(H_ABC));

    // Back-to-back "abc" with random valid toggling.
    core_lat = 2;
    build_msg(3, 3, m);
    model_push(m);
    model_push(m);
    h0 = n_hv;
    send_msg(m, 1'b1);
    send_msg(m, 1'b1);
    wait_hash(h0 + 2);
    check("b2b_first", z256(hash_log[hash_log.size() - 2]), z256(H_ABC));
    check("b2b_second", z256(hash_log[hash_log.size() - 1]), z256(H_ABC));

    repeat (5) @(negedge clk);
    check("model_blocks_drained", z32(32'(exp_blk.size())), z32(32'd0));
    check("model_hashes_drained", z32(32'(exp_hash.size())), z32(32'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm3_msg_pad.md
SM3_MSG_PAD -- requirements
Module: sm3_msg_pad

Interface
REQ-001 SHALL have parameter IV, default 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e, the SM3 initial hash value.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  input word valid
- i_data  in  32  message word, big-endian; first byte in [31:24]
- i_last  in  1  final word of message; qualifies i_nbytes
- i_nbytes  in  3  valid bytes in last word, 0..4, left-aligned; ignored unless i_last
- o_ready  out  1  word accepted when i_valid && o_ready
- o_core_start  out  1  one-cycle start pulse to compression core
- o_core_data  out  512  padded block; W0 in [511:480]
- o_core_vin  out  256  chaining value to core
- i_core_vout  in  256  core result
- i_core_done  in  1  core result valid, one cycle
- o_hash  out  256  final digest
- o_hash_valid  out  1  digest valid, one cycle

Function
REQ-003 SHALL implement states FILL, PAD, START, WAIT, DONE; reset state FILL.
REQ-004 FILL: o_ready=1; each accepted word SHALL be written to block word r_wcnt, r_wcnt increments, and the 64-bit byte counter SHALL add 4, or i_nbytes on the last word.
REQ-005 Non-last word at r_wcnt==15 SHALL complete the block: FILL->START, o_ready=0 from the next cycle.
REQ-006 Last word with i_nbytes<4 SHALL have byte i_nbytes set to 0x80 and lower bytes zeroed. With i_nbytes==4, 0x80 SHALL go in [31:24] of the next word. Then FILL->PAD; o_ready=0 until next message.
REQ-007 i_nbytes==0 with i_last SHALL contribute no data bytes; the word becomes 32'h80000000. An empty message is one such word.
REQ-008 PAD SHALL zero-fill one word per cycle.
- If the 0x80 byte lies in words 0..13: words 14,15 SHALL hold the bit length (byte count << 3, 64-bit, modulo 2^64, big-endian); PAD->START with flag final=1.
- Otherwise: zero-fill through word 15; PAD->START with final=0 and pending_len=1.
REQ-009 START SHALL hold o_core_start=1 for exactly one cycle with o_core_data valid in that cycle, then go to WAIT.
REQ-010 o_core_data and o_core_vin SHALL remain stable from START until i_core_done.
REQ-011 WAIT: on i_core_done the chaining register SHALL load i_core_vout.
- final=1: go to DONE.
- pending_len=1: build a block of 14 zero words plus length and go to START.
- otherwise: clear r_wcnt and go to FILL.
REQ-012 DONE SHALL drive o_hash_valid=1 for one cycle with o_hash = chaining value, reload chaining register with IV, clear byte counter and flags, and go to FILL.
REQ-013 o_hash SHALL read 0 whenever o_hash_valid=0.
REQ-014 i_core_done outside WAIT SHALL be ignored; i_valid while o_ready=0 SHALL be ignored with no state change.
REQ-015 Throughput: a full block SHALL be followed by START on the next cycle. Input stalls only during START/WAIT/PAD/DONE.

Reset
REQ-016 i_rst SHALL, at any time including mid-block or mid-WAIT, force state FILL and chaining register = IV. Byte counter, r_wcnt, flags and block buffer SHALL be cleared. o_ready SHALL be 1 from the first cycle after reset. o_core_start, o_hash_valid and o_hash SHALL be 0 during and after reset.
REQ-017 A core result arriving after reset SHALL be discarded.

Verification (bench connects the SM3 compression core)
REQ-018 Message "abc": one word 32'h61626300, i_last, i_nbytes=3. Required response:
- one block, W0=32'h61626380, W15=32'h18
- o_hash=66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0
REQ-019 Message "abcd"x16: 16 words 32'h61626364, the last with i_nbytes=4. Required response:
- two core starts; second block W0=32'h80000000, W15=32'h200
- o_hash=debe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732
REQ-020 Empty message: one word, i_last, i_nbytes=0. Required response:
- W0=32'h80000000, length 0
- o_hash=1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b
REQ-021 56-byte message (14 words, last i_nbytes=4). Required response:
- second block SHALL be zeros plus length 32'h1c0
- check the 0x80 overflow path and pending_len handling
REQ-022 Assert i_rst during WAIT of the REQ-019 run, then rerun "abc". Required response:
- late i_core_done ignored
- digest matches REQ-018
- o_hash_valid pulses exactly once
REQ-023 Back-to-back: "abc" immediately followed by "abc", with i_valid toggled randomly. Required response:
- two identical digests
- chaining value restarted from IV
